wash_billing: RTL and testbench

Charge-accounting stage downstream of the admin price-setting block in the washing-machine controller. It takes the BCD price table and overtime fine produced by admin mode, builds the bill for each wash order, and adds per-period overtime fines while washed clothes sit uncollected. On collection it accumulates the bill into the profit register, which admin mode reads for display and reset.

---
 rtl/wash_billing.sv | 192 +++++++++++++++++++
 tb/tb_wash_billing.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wash_billing.sv
// Billing stage of the washing-machine controller: prices each order, adds
// overtime fines while clothes wait uncollected, and banks the bill into profit.
module wash_billing #(
  parameter int GRACE       = 10,
  parameter int FINE_PERIOD = 60,
  parameter int SEC_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] dy_price,
  input  logic [11:0] s_price,
  input  logic [11:0] m_price,
  input  logic [11:0] b_price,
  input  logic [11:0] setfine,
  input  logic [11:0] profit_in,
  input  logic        load_profit,
  input  logic [1:0]  size,
  input  logic        dry,
  input  logic        start,
  input  logic        wash_done,
  input  logic        collect,
  input  logic        tick_1s,
  output logic [11:0] bill,
  output logic [11:0] profit,
  output logic        busy,
  output logic        overdue,
  output logic        paid,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRICE  = 3'd1,
    S_WASH   = 3'd2,
    S_HOLD   = 3'd3,
    S_OVER   = 3'd4,
    S_SETTLE = 3'd5
  } state_t;

  localparam logic [SEC_W:0] GRACE_CNT = (SEC_W+1)'(GRACE);
  localparam logic [SEC_W:0] FINE_CNT  = (SEC_W+1)'(FINE_PERIOD);

  // Digit-wise BCD add; digits above 9 count as 9, and a carry out of the
  // hundreds digit pins the result at 999.
  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] sum;
    logic        carry;
    logic [3:0]  da;
    logic [3:0]  db;
    logic [4:0]  d;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da > 4'd9) da = 4'd9;
      if (db > 4'd9) db = 4'd9;
      d = {1'b0, da} + {1'b0, db} + {4'b0, carry};
      if (d > 5'd9) begin
        d     = d - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = d[3:0];
    end
    return carry ? 12'h999 : sum;
  endfunction

  state_t          state_q, state_n;
  logic [11:0]     bill_n, profit_n;
  logic [SEC_W-1:0] sec_q, sec_n;
  logic [SEC_W:0]  sec_inc;
  logic [11:0]     add_a, add_b, add_sum, size_price;

  assign sec_inc = {1'b0, sec_q} + {{SEC_W{1'b0}}, 1'b1};
  assign state   = state_q;

  always_comb begin
    case (size)
      2'b01:   size_price = s_price;
      2'b10:   size_price = m_price;
      2'b11:   size_price = b_price;
      default: size_price = 12'h000;
    endcase
  end

  // Operand steering for the single shared adder.
  always_comb begin
    add_a = 12'h000;
    add_b = 12'h000;
    case (state_q)
      S_IDLE:   add_b = size_price;
      S_PRICE: begin
        add_a = bill;
        add_b = dry ? dy_price : 12'h000;
      end
      S_OVER: begin
        add_a = bill;
        add_b = setfine;
      end
      S_SETTLE: begin
        add_a = load_profit ? profit_in : profit;
        add_b = bill;
      end
      default: ;
    endcase
  end

  assign add_sum = bcd_add(add_a, add_b);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missed assignment in always_comb would infer a latch.
  always_comb begin
    state_n  = state_q;
    bill_n   = bill;
    profit_n = profit;
    sec_n    = sec_q;
    case (state_q)
      S_IDLE: begin
        if (start && size != 2'b00) begin
          bill_n  = add_sum;
          state_n = S_PRICE;
        end
      end
      S_PRICE: begin
        bill_n  = add_sum;
        state_n = S_WASH;
      end
      S_WASH: begin
        if (wash_done) begin
          sec_n   = '0;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (collect) begin
          state_n = S_SETTLE;
        end else if (tick_1s) begin
          if (sec_inc == GRACE_CNT) begin
            sec_n   = '0;
            state_n = S_OVER;
          end else begin
            sec_n = sec_inc[SEC_W-1:0];
          end
        end
      end
      S_OVER: begin
        if (collect) begin
          state_n = S_SETTLE;
        end else if (tick_1s) begin
          if (sec_inc == FINE_CNT) begin
            bill_n = add_sum;
            sec_n  = '0;
          end else begin
            sec_n = sec_inc[SEC_W-1:0];
          end
        end
      end
      S_SETTLE: begin
        profit_n = add_sum;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Outside SETTLE an admin load simply overwrites the register.
    if (load_profit && state_q != S_SETTLE) profit_n = profit_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bill    <= 12'h000;
      profit  <= 12'h000;
      sec_q   <= '0;
      busy    <= 1'b0;
      overdue <= 1'b0;
      paid    <= 1'b0;
    end else begin
      state_q <= state_n;
      bill    <= bill_n;
      profit  <= profit_n;
      sec_q   <= sec_n;
      busy    <= (state_n != S_IDLE);
      overdue <= (state_n == S_OVER);
      paid    <= (state_q == S_SETTLE);
    end
  end

endmodule

// File: tb/tb_wash_billing.sv
// Directed bench for wash_billing with short grace/fine periods so overtime
// fines, BCD carries and saturation are reached in a handful of ticks.
module tb_wash_billing;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] dy_price, s_price, m_price, b_price, setfine, profit_in;
  logic        load_profit, dry, start, wash_done, collect, tick_1s;
  logic [1:0]  size;
  logic [11:0] bill, profit;
  logic        busy, overdue, paid;
  logic [2:0]  state;

  int vectors     = 0;
  int miscompares = 0;

  wash_billing #(.GRACE(2), .FINE_PERIOD(2), .SEC_W(8)) dut (
    .clk(clk), .rst(rst),
    .dy_price(dy_price), .s_price(s_price), .m_price(m_price), .b_price(b_price),
    .setfine(setfine), .profit_in(profit_in), .load_profit(load_profit),
    .size(size), .dry(dry), .start(start), .wash_done(wash_done),
    .collect(collect), .tick_1s(tick_1s),
    .bill(bill), .profit(profit), .busy(busy), .overdue(overdue),
    .paid(paid), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1; step(); tick_1s = 1'b0;
    end
  endtask

  // Order from IDLE through PRICE into WASH, then wash_done into HOLD.
  task automatic run_to_hold(input logic [1:0] sz, input logic dr);
    size = sz; dry = dr; start = 1'b1; step(); start = 1'b0;
    step();
    wash_done = 1'b1; step(); wash_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    dy_price = 12'h005; s_price = 12'h015; m_price = 12'h03A; b_price = 12'h990;
    setfine = 12'h007; profit_in = 12'h000; load_profit = 1'b0;
    size = 2'b00; dry = 1'b0; start = 1'b0; wash_done = 1'b0;
    collect = 1'b0; tick_1s = 1'b0;
    step(); step();
    check("rst_state", 12'(state), 12'h000);
    check("rst_bill", bill, 12'h000);
    check("rst_profit", profit, 12'h000);
    check("rst_flags", {9'b0, busy, overdue, paid}, 12'h000);
    rst = 1'b1;
    step();

    // Basic order: small + dry, collected before any tick.
    size = 2'b01; dry = 1'b1; start = 1'b1; step(); start = 1'b0;
    check("basic_price_state", 12'(state), 12'h001);
    check("basic_price_bill", bill, 12'h015);
    check("basic_busy", 12'(busy), 12'h001);
    step();
    check("basic_wash_bill", bill, 12'h020);
    check("basic_wash_state", 12'(state), 12'h002);
    collect = 1'b1; step(); collect = 1'b0;
    check("collect_in_wash", 12'(state), 12'h002);
    wash_done = 1'b1; step(); wash_done = 1'b0;
    check("basic_hold", 12'(state), 12'h003);
    collect = 1'b1; step(); collect = 1'b0;
    check("basic_settle", 12'(state), 12'h005);
    check("basic_paid_early", 12'(paid), 12'h000);
    step();
    check("basic_paid", 12'(paid), 12'h001);
    check("basic_profit", profit, 12'h020);
    check("basic_idle", 12'(state), 12'h000);
    check("basic_busy_low", 12'(busy), 12'h000);
    step();
    check("basic_paid_once", 12'(paid), 12'h000);

    // Fines: grace 2 ticks, a fine every 2 ticks, BCD carry on the second.
    run_to_hold(2'b01, 1'b1);
    pulse_tick(1);
    check("grace_not_over", 12'(overdue), 12'h000);
    pulse_tick(1);
    check("grace_over", 12'(overdue), 12'h001);
    check("grace_state", 12'(state), 12'h004);
    pulse_tick(2);
    check("fine1", bill, 12'h027);
    pulse_tick(2);
    check("fine2_carry", bill, 12'h034);
    collect = 1'b1; step(); collect = 1'b0;
    check("fine_overdue_fall", 12'(overdue), 12'h000);
    step();
    check("fine_profit", profit, 12'h054);

    // Collect on the fine-completing tick: no fine; load_profit in SETTLE.
    run_to_hold(2'b01, 1'b1);
    pulse_tick(4);
    check("tie_pre_bill", bill, 12'h027);
    pulse_tick(1);
    collect = 1'b1; tick_1s = 1'b1; step(); collect = 1'b0; tick_1s = 1'b0;
    check("tie_state", 12'(state), 12'h005);
    check("tie_no_fine", bill, 12'h027);
    load_profit = 1'b1; profit_in = 12'h000; step(); load_profit = 1'b0;
    check("settle_load_profit", profit, 12'h027);

    // Admin load in IDLE, then a saturating order and saturating settle.
    profit_in = 12'h990; load_profit = 1'b1; step(); load_profit = 1'b0;
    check("idle_load_profit", profit, 12'h990);
    dy_price = 12'h020;
    size = 2'b11; dry = 1'b1; start = 1'b1; step(); start = 1'b0;
    check("sat_base", bill, 12'h990);
    step();
    check("sat_bill", bill, 12'h999);
    wash_done = 1'b1; step(); wash_done = 1'b0;
    collect = 1'b1; step(); collect = 1'b0;
    step();
    check("sat_profit", profit, 12'h999);

    // Start with no size selected is ignored.
    size = 2'b00; start = 1'b1; step(); start = 1'b0;
    check("nosize_state", 12'(state), 12'h000);
    check("nosize_bill", bill, 12'h999);

    // Asynchronous reset while overdue.
    dy_price = 12'h005;
    run_to_hold(2'b01, 1'b1);
    pulse_tick(2);
    check("pre_rst_over", 12'(state), 12'h004);
    #2 rst = 1'b0;
    #1;
    check("async_state", 12'(state), 12'h000);
    check("async_bill", bill, 12'h000);
    check("async_profit", profit, 12'h000);
    check("async_flags", {9'b0, busy, overdue, paid}, 12'h000);
    step();
    rst = 1'b1;
    step();

    // Fresh order after reset; medium price digit 0xA counts as 9.
    size = 2'b10; dry = 1'b1; start = 1'b1; step(); start = 1'b0;
    check("post_rst_clamp", bill, 12'h039);
    step();
    check("post_rst_dry", bill, 12'h044);
    check("post_rst_wash", 12'(state), 12'h002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
